// File: rtl/blk_mem_ram.sv
// rtl/blk_mem_ram.sv - simple dual-port block RAM, one write port, one registered read port
module blk_mem_ram #(
   parameter int BIT_WIDTH  = 16,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [BIT_WIDTH-1:0]  wr_data,
   output logic [BIT_WIDTH-1:0]  rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Storage array; never reset so synthesis can map it onto block RAM.
   logic [BIT_WIDTH-1:0] mem [DEPTH];

   // Write port: rst_n gates the write so a reset landing on an edge aborts it.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem[addr_in] <= wr_data;
      end
   end

   // Read port: read-first on collisions because the array update is non-blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[addr_out];
      end
   end

endmodule

// File: tb/tb_blk_mem_ram.sv
// tb/tb_blk_mem_ram.sv - directed self-checking bench for blk_mem_ram
module tb_blk_mem_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [8:0]  addr_in;
   logic [8:0]  addr_out;
   logic [15:0] wr_data;
   logic [15:0] rd_data;

   int checks   = 0;
   int failures = 0;

   blk_mem_ram #(
      .BIT_WIDTH  (16),
      .ADDR_WIDTH (9)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .addr_in  (addr_in),
      .addr_out (addr_out),
      .wr_data  (wr_data),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      addr_in  = 9'd0;
      addr_out = 9'd5;
      wr_data  = 16'h0000;

      // reset holds output at zero
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_hold", rd_data, 16'h0000);
      end
      rst_n = 1'b1;

      // write 0x1234 @ 3 and 0xBEEF @ 256
      wr_en = 1'b1; addr_in = 9'd3; wr_data = 16'h1234;
      tick();
      addr_in = 9'd256; wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0;
      addr_out = 9'd3;
      tick();
      chk("read_3", rd_data, 16'h1234);
      addr_out = 9'd256;
      tick();
      chk("read_256", rd_data, 16'hBEEF);

      // asynchronous reset between edges clears output immediately
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", rd_data, 16'h0000);
      rst_n = 1'b1;
      tick();
      chk("retain_after_reset", rd_data, 16'hBEEF);

      // collision is read-first
      wr_en = 1'b1; addr_in = 9'd7; wr_data = 16'hAAAA;
      tick();
      wr_data = 16'h5555; addr_out = 9'd7;
      tick();
      chk("collision_old", rd_data, 16'hAAAA);
      wr_en = 1'b0;
      tick();
      chk("collision_new", rd_data, 16'h5555);

      // wr_en gating
      wr_en = 1'b1; addr_in = 9'd10; wr_data = 16'h0F0F;
      tick();
      wr_en = 1'b0; wr_data = 16'hFFFF;
      for (int i = 0; i < 4; i++) tick();
      addr_out = 9'd10;
      tick();
      chk("wr_en_gating", rd_data, 16'h0F0F);

      // streaming fill and sweep of the full address range
      wr_en = 1'b1;
      for (int i = 0; i < 512; i++) begin
         addr_in = 9'(i);
         wr_data = 16'(i);
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 512; i++) begin
         addr_out = 9'(i);
         tick();
         chk($sformatf("sweep_%0d", i), rd_data, 16'(i));
      end

      // reset landing on a write edge aborts that write
      wr_en = 1'b1; addr_in = 9'd20; wr_data = 16'h7777;
      rst_n = 1'b0;
      #1;
      chk("midop_reset_immediate", rd_data, 16'h0000);
      tick();
      chk("midop_reset_out", rd_data, 16'h0000);
      wr_en = 1'b0;
      rst_n = 1'b1;
      addr_out = 9'd20;
      tick();
      chk("aborted_write_20", rd_data, 16'd20);
      addr_out = 9'd511;
      tick();
      chk("retained_511", rd_data, 16'd511);
      addr_out = 9'd256;
      tick();
      chk("retained_256", rd_data, 16'd256);
      addr_out = 9'd0;
      tick();
      chk("retained_0", rd_data, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
